// File: rtl/cpu_commit_stage_pkg.sv
// Shared CPU pipeline definitions used by the commit stage and its bus interface.
// Data/address and register-index widths are fixed here for the whole pipeline.
package cpu_commit_stage_pkg;

  localparam int REG_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [2:0] {
    ST_EMPTY    = 3'd0,
    ST_ALU_WB   = 3'd1,
    ST_MEM_REQ  = 3'd2,
    ST_MEM_RESP = 3'd3,
    ST_LOAD_WB  = 3'd4
  } commit_state_t;

  function automatic logic is_mem_op(input mem_op_t op);
    return (op == MEM_LOAD) || (op == MEM_STORE);
  endfunction

endpackage

// File: rtl/cpu_commit_stage_if.sv
// Bus bundle around the commit stage: execute-side handshake, data-memory port,
// writeback/forwarding outputs. The stage uses the slave modport; its environment the master.
interface cpu_commit_stage_if;
  import cpu_commit_stage_pkg::*;

  // Execute -> commit: an instruction moves when in_valid && in_ready are both high
  // at a rising clock edge; in_ready depends only on the stage state.
  logic                      in_valid;
  logic                      in_ready;
  logic [REG_WIDTH-1:0]      in_alu_result;
  logic [REG_WIDTH-1:0]      in_rb_data;
  logic [REG_ADDR_WIDTH-1:0] in_reg_dest;
  logic                      in_writeback;
  mem_op_t                   in_mem_op;

  logic                      mem_req;
  logic                      mem_we;
  logic [REG_WIDTH-1:0]      mem_addr;
  logic [REG_WIDTH-1:0]      mem_wdata;
  logic                      mem_gnt;
  logic                      mem_rvalid;
  logic [REG_WIDTH-1:0]      mem_rdata;

  logic                      wb_valid;
  logic [REG_ADDR_WIDTH-1:0] wb_reg;
  logic [REG_WIDTH-1:0]      wb_value;
  logic                      fw_valid;
  logic [REG_ADDR_WIDTH-1:0] fw_reg;
  logic [REG_WIDTH-1:0]      commit_value;
  logic                      load_pending;
  logic                      zero;

  modport master (
    output in_valid, in_alu_result, in_rb_data, in_reg_dest, in_writeback, in_mem_op,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  wb_valid, wb_reg, wb_value, fw_valid, fw_reg, commit_value, load_pending, zero
  );

  modport slave (
    input  in_valid, in_alu_result, in_rb_data, in_reg_dest, in_writeback, in_mem_op,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output wb_valid, wb_reg, wb_value, fw_valid, fw_reg, commit_value, load_pending, zero
  );

endinterface

// File: rtl/cpu_commit_stage.sv
// Commit stage: holds one instruction, runs its data-memory access, then retires the
// result to the register file and forwarding unit, stalling execute while memory is busy.
module cpu_commit_stage
  import cpu_commit_stage_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  cpu_commit_stage_if.slave   bus,
  output commit_state_t       dbg_state
);

  commit_state_t             r_state;
  commit_state_t             w_state_nxt;
  logic [REG_WIDTH-1:0]      r_result;
  logic [REG_WIDTH-1:0]      r_rb_data;
  logic [REG_ADDR_WIDTH-1:0] r_reg_dest;
  logic                      r_writeback;
  mem_op_t                   r_mem_op;
  logic                      r_zero;

  logic                      w_ready;
  logic                      w_accept;
  logic                      w_wb_valid;
  logic [REG_ADDR_WIDTH-1:0] w_wb_reg;
  logic [REG_WIDTH-1:0]      w_wb_value;
  logic                      w_load_capture;

  assign w_ready  = (r_state == ST_EMPTY) || (r_state == ST_ALU_WB) ||
                    (r_state == ST_LOAD_WB);
  assign w_accept = bus.in_valid && w_ready;
  assign w_load_capture = (r_state == ST_MEM_RESP) && bus.mem_rvalid;

  always_comb begin
    w_state_nxt      = r_state;
    w_wb_valid       = 1'b0;
    w_wb_reg         = '0;
    w_wb_value       = '0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;
    bus.load_pending = 1'b0;

    case (r_state)
      ST_EMPTY: ;
      ST_ALU_WB, ST_LOAD_WB: begin
        w_wb_valid  = r_writeback;
        w_wb_reg    = r_reg_dest;
        w_wb_value  = r_result;
        w_state_nxt = ST_EMPTY;
      end
      ST_MEM_REQ: begin
        // r_result still holds the address here; it is reused for load data later
        bus.mem_req      = 1'b1;
        bus.mem_we       = (r_mem_op == MEM_STORE);
        bus.mem_addr     = r_result;
        bus.mem_wdata    = r_rb_data;
        bus.load_pending = (r_mem_op == MEM_LOAD);
        if (bus.mem_gnt) begin
          w_state_nxt = (r_mem_op == MEM_STORE) ? ST_EMPTY : ST_MEM_RESP;
        end
      end
      ST_MEM_RESP: begin
        bus.load_pending = (r_mem_op == MEM_LOAD);
        if (bus.mem_rvalid) begin
          w_state_nxt = ST_LOAD_WB;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase

    if (w_accept) begin
      w_state_nxt = is_mem_op(bus.in_mem_op) ? ST_MEM_REQ : ST_ALU_WB;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_result    <= '0;
      r_rb_data   <= '0;
      r_reg_dest  <= '0;
      r_writeback <= 1'b0;
      r_mem_op    <= MEM_NONE;
      r_zero      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_result    <= bus.in_alu_result;
        r_rb_data   <= bus.in_rb_data;
        r_reg_dest  <= bus.in_reg_dest;
        r_writeback <= bus.in_writeback;
        r_mem_op    <= bus.in_mem_op;
      end else if (w_load_capture) begin
        r_result <= bus.mem_rdata;
      end
      if (w_wb_valid) begin
        r_zero <= (w_wb_value == '0);
      end
    end
  end

  assign bus.in_ready     = w_ready;
  assign bus.wb_valid     = w_wb_valid;
  assign bus.wb_reg       = w_wb_reg;
  assign bus.wb_value     = w_wb_value;
  assign bus.fw_valid     = w_wb_valid;
  assign bus.fw_reg       = w_wb_reg;
  assign bus.commit_value = w_wb_value;
  assign bus.zero         = r_zero;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_cpu_commit_stage.sv
// Bench for cpu_commit_stage: reset, table of ALU ops, hand-written memory sequences,
// then random traffic checked against a transaction-level model of the stage.
module tb_cpu_commit_stage;
  import cpu_commit_stage_pkg::*;

  localparam int W = REG_ADDR_WIDTH + REG_WIDTH;
  localparam int RAND_CYCLES = 2000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  commit_state_t dbg_state;

  cpu_commit_stage_if bus ();

  cpu_commit_stage dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard ----------------
  int              n_pass   = 0;
  int              n_checks = 0;
  logic [W-1:0]    exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid      = 1'b0;
    bus.in_alu_result = '0;
    bus.in_rb_data    = '0;
    bus.in_reg_dest   = '0;
    bus.in_writeback  = 1'b0;
    bus.in_mem_op     = MEM_NONE;
    bus.mem_gnt       = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic drive_op(input logic [4:0] dest, input logic [31:0] val,
                          input logic [31:0] rb, input logic wbk, input mem_op_t op);
    bus.in_valid      = 1'b1;
    bus.in_reg_dest   = dest;
    bus.in_alu_result = val;
    bus.in_rb_data    = rb;
    bus.in_writeback  = wbk;
    bus.in_mem_op     = op;
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] val;
    logic        wbk;
    logic        exp_wb_valid;
    logic        exp_zero;   // zero flag seen in the cycle this op retires
  } alu_vec_t;

  alu_vec_t vecs[5];

  // random-phase model state
  int           phase;       // 0 idle/retiring, 1 awaiting grant, 2 awaiting load data
  mem_op_t      m_op;
  logic [31:0]  m_addr;
  logic [31:0]  m_wdata;
  logic [4:0]   m_dest;
  logic         m_wb;
  logic         retire_now;
  logic         m_zero;
  logic [31:0]  gnt_addr;
  logic [W-1:0] e;
  logic         have_e;

  initial begin
    vecs[0] = '{dest: 5'd3,  val: 32'd5,          wbk: 1'b1, exp_wb_valid: 1'b1, exp_zero: 1'b0};
    vecs[1] = '{dest: 5'd4,  val: 32'd0,          wbk: 1'b1, exp_wb_valid: 1'b1, exp_zero: 1'b0};
    vecs[2] = '{dest: 5'd9,  val: 32'h7,          wbk: 1'b0, exp_wb_valid: 1'b0, exp_zero: 1'b1};
    vecs[3] = '{dest: 5'd0,  val: 32'd0,          wbk: 1'b1, exp_wb_valid: 1'b1, exp_zero: 1'b1};
    vecs[4] = '{dest: 5'd31, val: 32'hFFFF_FFFF,  wbk: 1'b1, exp_wb_valid: 1'b1, exp_zero: 1'b1};

    // reset held with a load presented: nothing may be captured
    idle_inputs();
    drive_op(5'd5, 32'hABCD, 32'h1, 1'b1, MEM_LOAD);
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_zero", bus.zero, 1'b0);
    check("rst_load_pending", bus.load_pending, 1'b0);
    check("rst_state", dbg_state, ST_EMPTY);
    idle_inputs();
    @(negedge clock) reset = 1'b1;
    step();
    check("post_rst_state", dbg_state, ST_EMPTY);
    check("post_rst_mem_req", bus.mem_req, 1'b0);

    // back-to-back ALU ops from the table
    for (int i = 0; i < 5; i++) begin
      drive_op(vecs[i].dest, vecs[i].val, 32'h0, vecs[i].wbk, MEM_NONE);
      step();
      check("alu_wb_valid", bus.wb_valid, vecs[i].exp_wb_valid);
      check("alu_fw_valid", bus.fw_valid, vecs[i].exp_wb_valid);
      check("alu_zero", bus.zero, vecs[i].exp_zero);
      check("alu_in_ready", bus.in_ready, 1'b1);
      if (vecs[i].exp_wb_valid) begin
        check("alu_wb_reg", bus.wb_reg, vecs[i].dest);
        check("alu_wb_value", bus.wb_value, vecs[i].val);
        check("alu_fw_reg", bus.fw_reg, vecs[i].dest);
        check("alu_commit_value", bus.commit_value, vecs[i].val);
      end
    end
    idle_inputs();
    step();
    check("alu_tail_zero", bus.zero, 1'b0);
    check("alu_tail_wb_valid", bus.wb_valid, 1'b0);
    check("alu_tail_state", dbg_state, ST_EMPTY);

    // store, grant on the fourth request cycle
    drive_op(5'd2, 32'h100, 32'hDEAD, 1'b1, MEM_STORE);
    step();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      check("st_mem_req", bus.mem_req, 1'b1);
      check("st_mem_we", bus.mem_we, 1'b1);
      check("st_mem_addr", bus.mem_addr, 32'h100);
      check("st_mem_wdata", bus.mem_wdata, 32'hDEAD);
      check("st_in_ready", bus.in_ready, 1'b0);
      check("st_wb_valid", bus.wb_valid, 1'b0);
      check("st_load_pending", bus.load_pending, 1'b0);
      bus.mem_gnt = (c == 3);
      step();
    end
    bus.mem_gnt = 1'b0;
    check("st_done_mem_req", bus.mem_req, 1'b0);
    check("st_done_in_ready", bus.in_ready, 1'b1);
    check("st_done_state", dbg_state, ST_EMPTY);
    check("st_done_wb_valid", bus.wb_valid, 1'b0);

    // load r7 from 0x40, immediate grant, data two cycles later
    drive_op(5'd7, 32'h40, 32'h0, 1'b1, MEM_LOAD);
    step();
    idle_inputs();
    check("ld_mem_req", bus.mem_req, 1'b1);
    check("ld_mem_we", bus.mem_we, 1'b0);
    check("ld_mem_addr", bus.mem_addr, 32'h40);
    check("ld_pending_req", bus.load_pending, 1'b1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("ld_resp_state", dbg_state, ST_MEM_RESP);
    check("ld_resp_mem_req", bus.mem_req, 1'b0);
    check("ld_resp_pending", bus.load_pending, 1'b1);
    check("ld_resp_in_ready", bus.in_ready, 1'b0);
    step();
    check("ld_resp_pending2", bus.load_pending, 1'b1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234;
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    check("ld_wb_valid", bus.wb_valid, 1'b1);
    check("ld_wb_reg", bus.wb_reg, 5'd7);
    check("ld_wb_value", bus.wb_value, 32'h1234);
    check("ld_fw_valid", bus.fw_valid, 1'b1);
    check("ld_fw_reg", bus.fw_reg, 5'd7);
    check("ld_commit_value", bus.commit_value, 32'h1234);
    check("ld_pending_done", bus.load_pending, 1'b0);
    check("ld_in_ready", bus.in_ready, 1'b1);

    // load without writeback: returns zero data that must not touch the zero flag
    drive_op(5'd9, 32'h44, 32'h0, 1'b0, MEM_LOAD);
    step();
    idle_inputs();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0;
    step();
    idle_inputs();
    check("ldnw_state", dbg_state, ST_LOAD_WB);
    check("ldnw_wb_valid", bus.wb_valid, 1'b0);
    check("ldnw_fw_valid", bus.fw_valid, 1'b0);
    step();
    check("ldnw_zero", bus.zero, 1'b0);

    // set zero, then reset in the middle of a load response
    drive_op(5'd1, 32'h0, 32'h0, 1'b1, MEM_NONE);
    step();
    idle_inputs();
    step();
    check("pre_rst_zero", bus.zero, 1'b1);
    drive_op(5'd12, 32'h80, 32'h0, 1'b1, MEM_LOAD);
    step();
    idle_inputs();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    check("mr_state_resp", dbg_state, ST_MEM_RESP);
    #2 reset = 1'b0;
    #1;
    check("mr_rst_state", dbg_state, ST_EMPTY);
    check("mr_rst_pending", bus.load_pending, 1'b0);
    check("mr_rst_in_ready", bus.in_ready, 1'b1);
    check("mr_rst_zero", bus.zero, 1'b0);
    @(negedge clock) reset = 1'b1;
    step();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0;
    step();
    bus.mem_rvalid = 1'b0;
    check("late_rvalid_wb_valid", bus.wb_valid, 1'b0);
    check("late_rvalid_state", dbg_state, ST_EMPTY);
    check("late_rvalid_zero", bus.zero, 1'b0);

    // reset while the request is on the bus: mem_req must drop without a clock edge
    drive_op(5'd13, 32'hC0, 32'h0, 1'b1, MEM_LOAD);
    step();
    idle_inputs();
    check("rq_mem_req", bus.mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rq_rst_mem_req", bus.mem_req, 1'b0);
    check("rq_rst_state", dbg_state, ST_EMPTY);
    @(negedge clock) reset = 1'b1;
    step();

    // random traffic against the transaction-level model
    exp_q.delete();
    phase      = 0;
    m_op       = MEM_NONE;
    m_addr     = '0;
    m_wdata    = '0;
    m_dest     = '0;
    m_wb       = 1'b0;
    retire_now = 1'b0;
    m_zero     = 1'b0;
    gnt_addr   = '0;
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      check("rnd_in_ready", bus.in_ready, phase == 0);
      check("rnd_load_pending", bus.load_pending, (phase != 0) && (m_op == MEM_LOAD));
      check("rnd_mem_req", bus.mem_req, phase == 1);
      if (phase == 1) begin
        check("rnd_mem_we", bus.mem_we, m_op == MEM_STORE);
        check("rnd_mem_addr", bus.mem_addr, m_addr);
        check("rnd_mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("rnd_wb_valid", bus.wb_valid, retire_now && m_wb);
      check("rnd_zero", bus.zero, m_zero);
      have_e = 1'b0;
      if (retire_now && m_wb) begin
        if (exp_q.size() == 0) begin
          check("rnd_exp_q_size", exp_q.size(), 1);
        end else begin
          e      = exp_q.pop_front();
          have_e = 1'b1;
          check("rnd_wb_data", {bus.wb_reg, bus.wb_value}, e);
          check("rnd_fw_valid", bus.fw_valid, 1'b1);
          check("rnd_fw_data", {bus.fw_reg, bus.commit_value}, e);
        end
      end

      bus.in_valid      = ($urandom_range(0, 99) < 70);
      bus.in_mem_op     = mem_op_t'($urandom_range(0, 2));
      bus.in_alu_result = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      bus.in_rb_data    = $urandom;
      bus.in_reg_dest   = 5'($urandom_range(0, 31));
      bus.in_writeback  = ($urandom_range(0, 3) != 0);
      bus.mem_gnt       = ($urandom_range(0, 99) < 40);
      bus.mem_rvalid    = ($urandom_range(0, 99) < 35);
      bus.mem_rdata     = mem_f(gnt_addr);

      if (have_e) m_zero = (e[REG_WIDTH-1:0] == '0);
      retire_now = 1'b0;
      case (phase)
        0: if (bus.in_valid) begin
          m_op    = bus.in_mem_op;
          m_addr  = bus.in_alu_result;
          m_wdata = bus.in_rb_data;
          m_dest  = bus.in_reg_dest;
          m_wb    = bus.in_writeback;
          if (m_op == MEM_NONE) begin
            retire_now = 1'b1;
            if (m_wb) exp_q.push_back({m_dest, m_addr});
          end else begin
            phase = 1;
          end
        end
        1: if (bus.mem_gnt) begin
          gnt_addr = m_addr;
          phase    = (m_op == MEM_STORE) ? 0 : 2;
        end
        default: if (bus.mem_rvalid) begin
          phase      = 0;
          retire_now = 1'b1;
          if (m_wb) exp_q.push_back({m_dest, mem_f(m_addr)});
        end
      endcase
      step();
    end

    idle_inputs();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
